// File: rtl/result_drain_if.sv
// result_drain_if: drain control, results-SRAM read port and the element stream of the drain controller.
interface result_drain_if #(
    parameter int ADDRESSSIZE    = 10,
    parameter int MATRIX_SIZE    = 32,
    parameter int PARTIAL_SUM_BW = 24
);
    logic                                  start;
    logic                                  abort;
    logic [ADDRESSSIZE-1:0]                base_addr;
    logic                                  rd_en;
    logic [ADDRESSSIZE-1:0]                rd_addr;
    logic [PARTIAL_SUM_BW*MATRIX_SIZE-1:0] rd_data;
    logic                                  m_valid;
    logic                                  m_ready;
    logic [PARTIAL_SUM_BW-1:0]             m_data;
    logic                                  m_last;
    logic                                  busy;
    logic                                  done;

    modport master (
        output start, abort, base_addr, rd_data, m_ready,
        input  rd_en, rd_addr, m_valid, m_data, m_last, busy, done
    );

    modport slave (
        input  start, abort, base_addr, rd_data, m_ready,
        output rd_en, rd_addr, m_valid, m_data, m_last, busy, done
    );
endinterface

// File: rtl/result_drain_ctrl.sv
// result_drain_ctrl: reads a MATRIX_SIZE x MATRIX_SIZE result tile row by row from the results SRAM
// and streams it element by element (LSB element first) over a valid/ready port.
module result_drain_ctrl #(
    parameter int ADDRESSSIZE    = 10,
    parameter int MATRIX_SIZE    = 32,
    parameter int PARTIAL_SUM_BW = 24
) (
    input logic           clk,
    input logic           rstn,
    result_drain_if.slave bus
);
    localparam int CW = MATRIX_SIZE > 1 ? $clog2(MATRIX_SIZE) : 1;
    localparam int RW = PARTIAL_SUM_BW * MATRIX_SIZE;
    localparam logic [CW-1:0] LAST = CW'(MATRIX_SIZE - 1);

    typedef enum logic [2:0] {IDLE, REQ, CAP, SEND, DONE} state_t;

    state_t                    state_q, state_d;
    logic [CW-1:0]             row_q, row_d, idx_q, idx_d;
    logic [ADDRESSSIZE-1:0]    base_q, base_d, rd_addr_q, rd_addr_d;
    logic [RW-1:0]             buf_q, buf_d;
    logic [PARTIAL_SUM_BW-1:0] m_data_q, m_data_d;
    logic                      rd_en_q, rd_en_d, m_valid_q, m_valid_d, m_last_q, m_last_d;
    logic                      busy_q, busy_d, done_q, done_d;

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        idx_d   = idx_q;
        base_d  = base_q;
        buf_d   = buf_q;
        if (bus.abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: if (bus.start) begin
                    base_d  = bus.base_addr;
                    row_d   = '0;
                    state_d = REQ;
                end
                REQ:  state_d = CAP;
                CAP: begin
                    buf_d   = bus.rd_data;
                    idx_d   = '0;
                    state_d = SEND;
                end
                SEND: if (bus.m_ready) begin
                    idx_d = idx_q + 1'b1;
                    if (idx_q == LAST) begin
                        state_d = (row_q == LAST) ? DONE : REQ;
                        row_d   = (row_q == LAST) ? row_q : row_q + 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
        // outputs are derived from the next state so every port comes straight off a flop
        rd_en_d   = state_d == REQ;
        rd_addr_d = base_d + ADDRESSSIZE'(row_d);
        m_valid_d = state_d == SEND;
        m_data_d  = buf_d[idx_d*PARTIAL_SUM_BW +: PARTIAL_SUM_BW];
        m_last_d  = state_d == SEND && row_d == LAST && idx_d == LAST;
        busy_d    = state_d != IDLE;
        done_d    = state_d == DONE;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= IDLE;
            row_q     <= '0;
            idx_q     <= '0;
            base_q    <= '0;
            buf_q     <= '0;
            rd_en_q   <= 1'b0;
            rd_addr_q <= '0;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            m_last_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            row_q     <= row_d;
            idx_q     <= idx_d;
            base_q    <= base_d;
            buf_q     <= buf_d;
            rd_en_q   <= rd_en_d;
            rd_addr_q <= rd_addr_d;
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
            m_last_q  <= m_last_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign bus.rd_en   = rd_en_q;
    assign bus.rd_addr = rd_addr_q;
    assign bus.m_valid = m_valid_q;
    assign bus.m_data  = m_data_q;
    assign bus.m_last  = m_last_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
endmodule

// File: tb/tb_result_drain_ctrl.sv
// tb_result_drain_ctrl: directed bench for the result drain controller with a one-cycle-latency SRAM model.
module tb_result_drain_ctrl;
    logic clk = 1'b0;
    logic rstn = 1'b0;
    int   total = 0;
    int   passed = 0;
    bit   saw_neg = 1'b0;

    logic [767:0] mem [1024];

    result_drain_if #(.ADDRESSSIZE(10), .MATRIX_SIZE(32), .PARTIAL_SUM_BW(24)) bus ();

    result_drain_ctrl #(.ADDRESSSIZE(10), .MATRIX_SIZE(32), .PARTIAL_SUM_BW(24)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (bus.rd_en) bus.rd_data <= mem[bus.rd_addr];

    typedef struct {
        int          cyc;
        logic        rd_en, m_valid, m_last, busy, done;
        logic [9:0]  addr;
        logic [23:0] data;
    } vec_t;

    vec_t tv [10];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one drain from base, checking read addresses, element order, stall stability and m_last.
    task automatic drain(input logic [9:0] base, input bit rnd, input bit tbl, input int xstart);
        int cyc, hs, nreq, ndone, done_cyc, r, k;
        bit fin, stall;
        logic [23:0] pd;
        logic pl;
        logic [767:0] w;
        cyc = 0; hs = 0; nreq = 0; ndone = 0; done_cyc = -1; fin = 0; stall = 0; pd = '0; pl = 0;
        bus.base_addr = base;
        bus.start     = 1'b1;
        bus.m_ready   = 1'b1;
        while (!fin && cyc < 4000) begin
            tick();
            cyc++;
            bus.start   = (cyc == xstart);
            bus.m_ready = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
            if (tbl) begin
                foreach (tv[i]) if (tv[i].cyc == cyc) begin
                    check($sformatf("tbl%0d_rd_en", i), bus.rd_en, tv[i].rd_en);
                    check($sformatf("tbl%0d_m_valid", i), bus.m_valid, tv[i].m_valid);
                    check($sformatf("tbl%0d_m_last", i), bus.m_last, tv[i].m_last);
                    check($sformatf("tbl%0d_busy", i), bus.busy, tv[i].busy);
                    check($sformatf("tbl%0d_done", i), bus.done, tv[i].done);
                    if (tv[i].rd_en) check($sformatf("tbl%0d_rd_addr", i), bus.rd_addr, tv[i].addr);
                    if (tv[i].m_valid) check($sformatf("tbl%0d_m_data", i), bus.m_data, tv[i].data);
                end
            end
            if (stall) begin
                check("stall_valid", bus.m_valid, 1'b1);
                check("stall_data", bus.m_data, pd);
                check("stall_last", bus.m_last, pl);
            end
            if (bus.rd_en) begin
                check("rd_addr", bus.rd_addr, 10'(base + 10'(nreq)));
                nreq++;
            end
            check("m_last", bus.m_last, bus.m_valid && hs == 1023);
            if (bus.m_valid) begin
                r = hs / 32;
                k = hs % 32;
                w = mem[10'(base + 10'(r))];
                check("m_data", bus.m_data, w[k*24 +: 24]);
                if (bus.m_ready && bus.m_data === 24'h800000) saw_neg = 1'b1;
                if (bus.m_ready) hs++;
            end
            stall = bus.m_valid && !bus.m_ready;
            pd = bus.m_data;
            pl = bus.m_last;
            if (bus.done) begin
                ndone++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (done_cyc > 0 && cyc == done_cyc + 1) fin = 1;
        end
        check("drain_timeout", fin, 1'b1);
        check("handshakes", hs, 1024);
        check("done_pulses", ndone, 1);
        check("row_reads", nreq, 32);
        check("idle_after_done", bus.busy, 1'b0);
        if (!rnd) check("done_cycle", done_cyc, 1089);
        bus.start   = 1'b0;
        bus.m_ready = 1'b1;
    endtask

    initial begin
        tv[0] = '{1,    1, 0, 0, 1, 0, 10'd0,  24'd0};
        tv[1] = '{2,    0, 0, 0, 1, 0, 10'd0,  24'd0};
        tv[2] = '{3,    0, 1, 0, 1, 0, 10'd0,  24'd0};
        tv[3] = '{34,   0, 1, 0, 1, 0, 10'd0,  24'd31};
        tv[4] = '{35,   1, 0, 0, 1, 0, 10'd1,  24'd0};
        tv[5] = '{37,   0, 1, 0, 1, 0, 10'd0,  24'd32};
        tv[6] = '{1055, 1, 0, 0, 1, 0, 10'd31, 24'd0};
        tv[7] = '{1088, 0, 1, 1, 1, 0, 10'd0,  24'd1023};
        tv[8] = '{1089, 0, 0, 0, 1, 1, 10'd0,  24'd0};
        tv[9] = '{1090, 0, 0, 0, 0, 0, 10'd0,  24'd0};
        for (int a = 0; a < 1024; a++)
            for (int k = 0; k < 32; k++) mem[a][k*24 +: 24] = 24'(a * 32 + k);
        mem[500][7*24 +: 24] = 24'h800000;

        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.base_addr = '0;
        bus.m_ready = 1'b1;
        #12;
        check("rst_busy", bus.busy, 1'b0);
        check("rst_rd_en", bus.rd_en, 1'b0);
        check("rst_m_valid", bus.m_valid, 1'b0);
        check("rst_done", bus.done, 1'b0);
        check("rst_rd_addr", bus.rd_addr, 10'd0);
        check("rst_m_data", bus.m_data, 24'd0);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        tick();

        drain(10'd0, 0, 1, 1089);
        drain(10'd1020, 0, 0, 0);
        drain(10'd0, 1, 0, 0);
        drain(10'd490, 0, 0, 0);
        check("neg_element_seen", saw_neg, 1'b1);

        bus.base_addr = 10'd0;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (182) tick();
        check("abort_pre_valid", bus.m_valid, 1'b1);
        check("abort_pre_data", bus.m_data, 24'd170);
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        check("abort_busy", bus.busy, 1'b0);
        check("abort_m_valid", bus.m_valid, 1'b0);
        check("abort_rd_en", bus.rd_en, 1'b0);
        check("abort_done", bus.done, 1'b0);
        begin
            bit any_done = 1'b0;
            repeat (5) begin
                tick();
                any_done |= bus.done;
            end
            check("abort_no_done", any_done, 1'b0);
        end
        drain(10'd0, 0, 0, 0);

        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (99) tick();
        check("reset_pre_valid", bus.m_valid, 1'b1);
        rstn = 1'b0;
        #1;
        check("reset_busy", bus.busy, 1'b0);
        check("reset_rd_en", bus.rd_en, 1'b0);
        check("reset_m_valid", bus.m_valid, 1'b0);
        check("reset_m_last", bus.m_last, 1'b0);
        check("reset_done", bus.done, 1'b0);
        check("reset_rd_addr", bus.rd_addr, 10'd0);
        check("reset_m_data", bus.m_data, 24'd0);
        @(posedge clk);
        #1;
        check("reset_held_busy", bus.busy, 1'b0);
        rstn = 1'b1;
        tick();
        check("reset_no_done", bus.done, 1'b0);
        drain(10'd0, 0, 0, 50);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
